// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the round-robin arbiter and the FIFO write port.
// With FIFO_ARB_TAG_EN defined, data_in carries the grant index above the payload.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);
`ifdef FIFO_ARB_TAG_EN
  localparam int DIN_WIDTH = DATA_WIDTH + ID_WIDTH;
`else
  localparam int DIN_WIDTH = DATA_WIDTH;
`endif

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          wr_en;
  logic [DIN_WIDTH-1:0]          data_in;
  logic [ID_WIDTH-1:0]           grant_id;
  logic                          busy;

  // master = arbiter, slave = producers plus FIFO write side
  modport master (
    input  req_valid, req_data, full,
    output req_ready, wr_en, data_in, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, full,
    input  req_ready, wr_en, data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers in bursts of up to MAX_BURST words.
// Optional FIFO_ARB_TAG_EN prefixes each written word with the source grant index.
//
// state | meaning
// IDLE  | no grant; pick next requester searching upward from rr_ptr
// GRANT | grant_id owns the write port until burst end or its valid drops
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input logic               clk,
  input logic               rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int ID_WIDTH  = $clog2(NUM_REQ);
  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [ID_WIDTH:0]    NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [CNT_WIDTH-1:0]  burst_cnt;
  logic                  busy;

  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH:0]     probe;
  logic                  found;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REQ-1:0]    ready;
  logic                  accept;

  // Wrap is done on a one-bit-wider sum so non-power-of-2 NUM_REQ works.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    probe  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      probe = {1'b0, rr_ptr} + (ID_WIDTH + 1)'(i);
      if (probe >= NUM_REQ_W) probe = probe - NUM_REQ_W;
      if (!found && bus.req_valid[probe[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = probe[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        ready[i]  = (state == GRANT) && !bus.full;
      end
    end
  end

  assign accept   = (state == GRANT) && sel_valid && !bus.full;
  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + ID_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= winner;
            burst_cnt <= '0;
            state     <= GRANT;
            busy      <= 1'b1;
          end
        end
        GRANT: begin
          if (!sel_valid) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
            busy   <= 1'b0;
          end else if (accept) begin
            burst_cnt <= burst_cnt + CNT_WIDTH'(1);
            if (burst_cnt == LAST_CNT) begin
              rr_ptr <= next_ptr;
              state  <= IDLE;
              busy   <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.wr_en     = accept;
  assign bus.grant_id  = grant_id;
  assign bus.busy      = busy;

`ifdef FIFO_ARB_TAG_EN
  assign bus.data_in = (state == GRANT) ? {grant_id, sel_data} : '0;
`else
  assign bus.data_in = (state == GRANT) ? sel_data : '0;
`endif

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));
  a_burst_bound:  assert property (@(posedge clk) disable iff (!rst_n) burst_cnt <= CNT_WIDTH'(MAX_BURST));
  a_wr_in_grant:  assert property (@(posedge clk) disable iff (!rst_n) bus.wr_en |-> busy);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4); honours FIFO_ARB_TAG_EN for the tag check.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
`ifdef FIFO_ARB_TAG_EN
  localparam int DINW = DW + 2;
`else
  localparam int DINW = DW;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus();
  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int         rem [NR];
  int         sent[NR];
  logic [7:0] base[NR];
  logic       full_q;

  logic            o_wr, o_busy;
  logic [NR-1:0]   o_ready;
  logic [1:0]      o_gid;
  logic [DINW-1:0] o_din;

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]           = (rem[i] > 0);
      bus.req_data[i*DW +: DW]   = base[i] + 8'(sent[i]);
    end
    bus.full = full_q;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    drive();
    #1;
    o_wr    = bus.wr_en;
    o_busy  = bus.busy;
    o_ready = bus.req_ready;
    o_gid   = bus.grant_id;
    o_din   = bus.data_in;
    for (int i = 0; i < NR; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        rem[i]--;
        sent[i]++;
      end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    full_q = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
      base[i] = 8'h10 * 8'(i + 1);
    end
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    rem[0] = 3;
    drive();
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", bus.busy); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%0h want=0", bus.req_ready); end
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0h want=0", bus.wr_en); end
    total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0h want=0", bus.grant_id); end
    total++; if (bus.data_in !== '0) begin bad++; $display("FAIL reset_data_in got=%0h want=0", bus.data_in); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_source();
    logic exp_wr[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int nw = 0;
    do_reset();
    rem[0] = 6;
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      total++;
      if (o_wr !== exp_wr[c]) begin bad++; $display("FAIL single_wr_en cyc=%0d got=%0h want=%0h", c, o_wr, exp_wr[c]); end
      if (o_wr === 1'b1 && exp_wr[c]) begin
        total++;
        if (o_din[DW-1:0] !== 8'h10 + 8'(nw)) begin bad++; $display("FAIL single_data cyc=%0d got=%0h want=%0h", c, o_din[DW-1:0], 8'h10 + 8'(nw)); end
        nw++;
      end
    end
    total++; if (nw !== 6) begin bad++; $display("FAIL single_count got=%0d want=6", nw); end
  endtask

  task automatic test_round_robin();
    int pos, g;
    logic [7:0] want;
    do_reset();
    for (int i = 0; i < NR; i++) rem[i] = 100;
    for (int c = 0; c < 25; c++) begin
      run_cycle();
      pos = c % 5;
      g   = (c / 5) % 4;
      total++;
      if (o_wr !== (pos != 0)) begin bad++; $display("FAIL rr_wr_en cyc=%0d got=%0h want=%0h", c, o_wr, (pos != 0)); end
      if (pos != 0) begin
        want = base[g] + 8'(4 * (c / 20) + pos - 1);
        total++;
        if (o_gid !== 2'(g)) begin bad++; $display("FAIL rr_grant_id cyc=%0d got=%0h want=%0h", c, o_gid, g); end
        total++;
        if (o_din[DW-1:0] !== want) begin bad++; $display("FAIL rr_data cyc=%0d got=%0h want=%0h", c, o_din[DW-1:0], want); end
      end
    end
  endtask

  task automatic test_full_stall();
    int nw = 0;
    do_reset();
    rem[1] = 6;
    run_cycle();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL full_first_idle got=%0h want=0", o_busy); end
    for (int c = 0; c < 2; c++) begin
      run_cycle();
      total++; if (o_wr !== 1'b1) begin bad++; $display("FAIL full_pre_wr cyc=%0d got=%0h want=1", c, o_wr); end
    end
    full_q = 1'b1;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      total++; if (o_wr !== 1'b0) begin bad++; $display("FAIL full_stall_wr cyc=%0d got=%0h want=0", c, o_wr); end
      total++; if (o_ready !== 4'b0000) begin bad++; $display("FAIL full_stall_ready cyc=%0d got=%0h want=0", c, o_ready); end
      total++; if (o_busy !== 1'b1 || o_gid !== 2'd1) begin bad++; $display("FAIL full_hold busy=%0h gid=%0h want busy=1 gid=1", o_busy, o_gid); end
    end
    full_q = 1'b0;
    run_cycle();
    total++; if (o_ready !== 4'b0010) begin bad++; $display("FAIL full_resume_ready got=%0h want=2", o_ready); end
    if (o_wr === 1'b1) nw++;
    for (int c = 0; c < 2; c++) begin
      run_cycle();
      if (o_wr === 1'b1) nw++;
    end
    total++; if (nw !== 2) begin bad++; $display("FAIL full_post_writes got=%0d want=2", nw); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL full_release got=%0h want=0", o_busy); end
  endtask

  task automatic test_valid_drop();
    do_reset();
    rem[2] = 2;
    rem[3] = 10;
    run_cycle();
    for (int c = 0; c < 2; c++) begin
      run_cycle();
      total++; if (o_wr !== 1'b1 || o_gid !== 2'd2) begin bad++; $display("FAIL drop_grant2 cyc=%0d wr=%0h gid=%0h want wr=1 gid=2", c, o_wr, o_gid); end
    end
    run_cycle();
    total++; if (o_busy !== 1'b1 || o_wr !== 1'b0) begin bad++; $display("FAIL drop_cycle busy=%0h wr=%0h want busy=1 wr=0", o_busy, o_wr); end
    run_cycle();
    total++; if (o_busy !== 1'b0 || o_gid !== 2'd2) begin bad++; $display("FAIL drop_idle busy=%0h gid=%0h want busy=0 gid=2", o_busy, o_gid); end
    run_cycle();
    total++; if (o_gid !== 2'd3 || o_wr !== 1'b1) begin bad++; $display("FAIL drop_next gid=%0h wr=%0h want gid=3 wr=1", o_gid, o_wr); end
    total++; if (o_din[DW-1:0] !== 8'h40) begin bad++; $display("FAIL drop_next_data got=%0h want=40", o_din[DW-1:0]); end
  endtask

  task automatic test_reset_mid_burst();
    int waited = 0;
    do_reset();
    rem[3] = 10;
    run_cycle();
    run_cycle();
    total++; if (o_gid !== 2'd3 || o_wr !== 1'b1) begin bad++; $display("FAIL midrst_pre gid=%0h wr=%0h want gid=3 wr=1", o_gid, o_wr); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin bad++; $display("FAIL midrst_async busy=%0h wr=%0h want 0 0", bus.busy, bus.wr_en); end
    total++; if (bus.req_ready !== 4'b0000 || bus.grant_id !== 2'd0) begin bad++; $display("FAIL midrst_async ready=%0h gid=%0h want 0 0", bus.req_ready, bus.grant_id); end
    for (int i = 0; i < NR; i++) rem[i] = 10;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    do begin
      run_cycle();
      waited++;
    end while (o_busy !== 1'b1 && waited < 4);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL midrst_timeout busy=%0h want=1", o_busy); end
    total++; if (o_gid !== 2'd0) begin bad++; $display("FAIL midrst_first_grant got=%0h want=0", o_gid); end
  endtask

  task automatic test_tag();
    logic [DINW-1:0] want;
    do_reset();
    rem[3]  = 1;
    base[3] = 8'hA5;
`ifdef FIFO_ARB_TAG_EN
    want = 10'h3A5;
`else
    want = 8'hA5;
`endif
    run_cycle();
    run_cycle();
    total++; if (o_wr !== 1'b1) begin bad++; $display("FAIL tag_wr_en got=%0h want=1", o_wr); end
    total++; if (o_din !== want) begin bad++; $display("FAIL tag_data_in got=%0h want=%0h", o_din, want); end
    total++; if (o_ready !== 4'b1000) begin bad++; $display("FAIL tag_ready got=%0h want=8", o_ready); end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_full_stall();
    test_valid_drop();
    test_reset_mid_burst();
    test_tag();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
